// File: rtl/sim_console.sv
// -----------------------------------------------------------------------------
// sim_console
//
// Memory-mapped console and run-control peripheral on the CPU data bus. It
// claims the top eight words of the data address space, starting at BASE_ADDR:
//   0 INSTR_CNT (R)   1 CYCLE_CNT (R)   2 STATUS (R, any write clears overflow)
//   3/4/5 channel 1/2/3 data (W)        6 channel 0 data (W)   7 HALT (W)
// Channel writes push {chan, byte} into a shared first-word-fall-through FIFO
// drained over a valid/ready port. A HALT write latches the exit code and
// moves RUN -> DRAIN. Once the FIFO is empty the block moves DRAIN -> HALTED
// and raises o_halt until reset.
//
// Optional feature macro: CONSOLE_COUNTERS_EN
//   defined     : 32-bit instruction and cycle counters at offsets 0 and 1
//   not defined : counters absent, offsets 0/1 read 0, i_instr_valid unused
//
// Ports
//   i_clk, i_rstb     clock, asynchronous active-low reset
//   i_clk_en          global enable; no state changes while low
//   i_addr/i_din      CPU data address / write data
//   i_wr/i_rd         write / read strobes
//   o_dout            registered read data, valid the cycle after i_rd
//   i_instr_valid     one pulse per retired instruction
//   o_tx_valid/data/chan, i_tx_ready   FIFO head, valid/ready handshake
//   o_halt            run terminated (sticky)
//   o_exit_code       byte written to HALT
// -----------------------------------------------------------------------------
module sim_console #(
    parameter int            AW        = 24,
    parameter logic [AW-1:0] BASE_ADDR = 24'hFFFFF8,
    parameter int            NCHAN     = 2,
    parameter int            DEPTH     = 16
) (
    input  logic          i_clk,
    input  logic          i_rstb,
    input  logic          i_clk_en,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_din,
    input  logic          i_wr,
    input  logic          i_rd,
    output logic [31:0]   o_dout,
    input  logic          i_instr_valid,
    output logic          o_tx_valid,
    output logic [7:0]    o_tx_data,
    output logic [1:0]    o_tx_chan,
    input  logic          i_tx_ready,
    output logic          o_halt,
    output logic [7:0]    o_exit_code
);

    localparam int LW = $clog2(DEPTH);

    localparam logic [2:0]  OFF_INSTR  = 3'd0;
    localparam logic [2:0]  OFF_CYCLE  = 3'd1;
    localparam logic [2:0]  OFF_STATUS = 3'd2;
    localparam logic [2:0]  OFF_HALT   = 3'd7;

    localparam logic [2:0]    NCHAN_L   = 3'(NCHAN);
    localparam logic [LW:0]   LVL_ZERO  = (LW+1)'(32'd0);
    localparam logic [LW:0]   LVL_ONE   = (LW+1)'(32'd1);
    localparam logic [LW:0]   LVL_FULL  = (LW+1)'(DEPTH);
    localparam logic [LW-1:0] PTR_ONE   = LW'(32'd1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Map a window offset to an output channel; bit 2 of the result flags a
    // channel data register (offset 6 is channel 0, offsets 3..5 are 1..3).
    function automatic logic [2:0] chan_decode(input logic [2:0] off);
        logic [2:0] res;
        case (off)
            3'd6:    res = 3'b100;
            3'd3:    res = 3'b101;
            3'd4:    res = 3'b110;
            3'd5:    res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // registered state
    state_e          state_q, state_d;
    logic [7:0]      exit_q, exit_d;
    logic            ovf_q, ovf_d;
    logic [LW:0]     level_q, level_d;
    logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [9:0]      mem_q [DEPTH];
    logic [9:0]      mem_d [DEPTH];
    logic [31:0]     dout_q, dout_d;
    logic            tx_valid_q, tx_valid_d;
    logic [9:0]      tx_head_q, tx_head_d;
    logic            halt_q, halt_d;
`ifdef CONSOLE_COUNTERS_EN
    logic [31:0]     cyc_cnt_q, cyc_cnt_d;
    logic [31:0]     ins_cnt_q, ins_cnt_d;
`endif

    // decoded bus / FIFO control
    logic            hit_s;
    logic            wr_s;
    logic            rd_s;
    logic [2:0]      off_s;
    logic [2:0]      chan_dec_s;
    logic            chan_ok_s;
    logic            full_s;
    logic            empty_s;
    logic            pop_s;
    logic            push_req_s;
    logic            push_s;
    logic [31:0]     status_s;
    logic            unused_s;

    assign hit_s      = (i_addr[AW-1:3] == BASE_ADDR[AW-1:3]);
    assign off_s      = i_addr[2:0];
    assign wr_s       = i_clk_en & i_wr & hit_s;
    assign rd_s       = i_clk_en & i_rd & hit_s;
    assign chan_dec_s = chan_decode(off_s);
    assign chan_ok_s  = chan_dec_s[2] & ({1'b0, chan_dec_s[1:0]} < NCHAN_L);
    assign full_s     = (level_q == LVL_FULL);
    assign empty_s    = (level_q == LVL_ZERO);
    assign pop_s      = ~empty_s & i_tx_ready & i_clk_en;
    // once a HALT has been seen, channel writes are silently discarded
    assign push_req_s = wr_s & chan_ok_s & (state_q == ST_RUN);
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign status_s   = {exit_q, 10'd0, state_q, 1'b0, empty_s, full_s, ovf_q,
                         8'(level_q)};

`ifdef CONSOLE_COUNTERS_EN
    assign unused_s = ^i_din[31:8];
`else
    assign unused_s = (^i_din[31:8]) ^ i_instr_valid;
`endif

    // Next-state logic for FIFO, FSM, counters and read data
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        state_d    = state_q;
        exit_d     = exit_q;
        dout_d     = dout_q;
`ifdef CONSOLE_COUNTERS_EN
        cyc_cnt_d  = cyc_cnt_q;
        ins_cnt_d  = ins_cnt_q;
`endif

        if (push_s) begin
            mem_d[wr_ptr_q] = {chan_dec_s[1:0], i_din[7:0]};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_s && !pop_s) begin
            level_d = level_q + LVL_ONE;
        end else if (pop_s && !push_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end

        if (push_req_s && !push_s) begin
            ovf_d = 1'b1;
        end else if (wr_s && (off_s == OFF_STATUS)) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            ST_RUN: begin
                if (wr_s && (off_s == OFF_HALT)) begin
                    state_d = ST_DRAIN;
                    exit_d  = i_din[7:0];
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (i_clk_en && empty_s) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase

`ifdef CONSOLE_COUNTERS_EN
        if (i_clk_en && (state_q != ST_HALTED)) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
            if (i_instr_valid) begin
                ins_cnt_d = ins_cnt_q + 32'd1;
            end else begin
                ins_cnt_d = ins_cnt_q;
            end
        end else begin
            cyc_cnt_d = cyc_cnt_q;
            ins_cnt_d = ins_cnt_q;
        end
`endif

        if (rd_s) begin
            case (off_s)
`ifdef CONSOLE_COUNTERS_EN
                OFF_INSTR:  dout_d = ins_cnt_q;
                OFF_CYCLE:  dout_d = cyc_cnt_q;
`endif
                OFF_STATUS: dout_d = status_s;
                default:    dout_d = 32'd0;
            endcase
        end else begin
            dout_d = dout_q;
        end
    end

    // Output-side next values: head of the post-update FIFO and halt flag
    always_comb begin
        tx_valid_d = (level_d != LVL_ZERO);
        tx_head_d  = mem_d[rd_ptr_d];
        halt_d     = (state_d == ST_HALTED);
    end

    // All state registers, asynchronously cleared
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q    <= ST_RUN;
            exit_q     <= 8'd0;
            ovf_q      <= 1'b0;
            level_q    <= LVL_ZERO;
            wr_ptr_q   <= LW'(32'd0);
            rd_ptr_q   <= LW'(32'd0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
            dout_q     <= 32'd0;
            tx_valid_q <= 1'b0;
            tx_head_q  <= 10'd0;
            halt_q     <= 1'b0;
`ifdef CONSOLE_COUNTERS_EN
            cyc_cnt_q  <= 32'd0;
            ins_cnt_q  <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            exit_q     <= exit_d;
            ovf_q      <= ovf_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            tx_head_q  <= tx_head_d;
            halt_q     <= halt_d;
`ifdef CONSOLE_COUNTERS_EN
            cyc_cnt_q  <= cyc_cnt_d;
            ins_cnt_q  <= ins_cnt_d;
`endif
        end
    end

    assign o_dout      = dout_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_tx_data   = tx_head_q[7:0];
    assign o_tx_chan   = tx_head_q[9:8];
    assign o_halt      = halt_q;
    assign o_exit_code = exit_q;

endmodule

// File: tb/tb_sim_console.sv
module tb_sim_console;

    localparam int          AW    = 24;
    localparam logic [23:0] BASE  = 24'hFFFFF8;
    localparam int          NCHAN = 2;
    localparam int          DEPTH = 16;
`ifdef CONSOLE_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rstb  = 1'b0;
    logic        en    = 1'b0;
    logic        wr    = 1'b0;
    logic        rd    = 1'b0;
    logic        iv    = 1'b0;
    logic        ready = 1'b0;
    logic [23:0] addr  = 24'd0;
    logic [31:0] din   = 32'd0;
    logic [23:0] base_v = BASE;

    logic [31:0] o_dout;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic [1:0]  o_tx_chan;
    logic        o_halt;
    logic [7:0]  o_exit_code;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int          m_level, pre_level;
    bit          m_ovf;
    int          m_state, pre_state;
    logic [7:0]  m_exit;
    logic [31:0] m_cyc, m_ins;
    bit          m_hit, m_pop;
    int          m_off, m_ch;
    logic [9:0]  exp_q[$];
    logic [31:0] rd_q[$];

    sim_console #(.AW(AW), .BASE_ADDR(BASE), .NCHAN(NCHAN), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rstb(rstb), .i_clk_en(en), .i_addr(addr), .i_din(din),
        .i_wr(wr), .i_rd(rd), .o_dout(o_dout), .i_instr_valid(iv),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .o_tx_chan(o_tx_chan),
        .i_tx_ready(ready), .o_halt(o_halt), .o_exit_code(o_exit_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        return {m_exit, 10'd0, 2'(m_state), 1'b0, 1'(m_level == 0),
                1'(m_level == DEPTH), m_ovf, 8'(m_level)};
    endfunction

    // Behavioural model: bytes are a queue, level a count, state an int
    initial begin
        forever begin
            @(posedge clk or negedge rstb);
            if (!rstb) begin
                m_level = 0; m_ovf = 1'b0; m_state = 0; m_exit = 8'd0;
                m_cyc = 32'd0; m_ins = 32'd0;
                exp_q.delete(); rd_q.delete();
            end else if (en) begin
                m_hit     = (addr[23:3] == base_v[23:3]);
                m_off     = int'(addr[2:0]);
                pre_level = m_level;
                pre_state = m_state;
                if (rd && m_hit) begin
                    case (m_off)
                        0:       rd_q.push_back(CNT_EN ? m_ins : 32'd0);
                        1:       rd_q.push_back(CNT_EN ? m_cyc : 32'd0);
                        2:       rd_q.push_back(model_status());
                        default: rd_q.push_back(32'd0);
                    endcase
                end
                m_pop = (pre_level > 0) && ready;
                if (wr && m_hit) begin
                    case (m_off)
                        6:       m_ch = 0;
                        3:       m_ch = 1;
                        4:       m_ch = 2;
                        5:       m_ch = 3;
                        default: m_ch = -1;
                    endcase
                    if (m_ch >= 0 && m_ch < NCHAN && pre_state == 0) begin
                        if (pre_level < DEPTH || m_pop) begin
                            exp_q.push_back({2'(m_ch), din[7:0]});
                            m_level++;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    if (m_off == 2) m_ovf = 1'b0;
                end
                if (m_pop) m_level--;
                if (pre_state == 0 && wr && m_hit && m_off == 7) begin
                    m_state = 1;
                    m_exit  = din[7:0];
                end else if (pre_state == 1 && pre_level == 0) begin
                    m_state = 2;
                end
                if (pre_state != 2) begin
                    m_cyc = m_cyc + 32'd1;
                    if (iv) m_ins = m_ins + 32'd1;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard on each falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rstb) begin
                chk("tx_valid", 32'(o_tx_valid), 32'(m_level != 0));
                if (o_tx_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL tx_unexpected: got 0x%0h with no byte expected", o_tx_data);
                    end else begin
                        chk("tx_data", 32'(o_tx_data), 32'(exp_q[0][7:0]));
                        chk("tx_chan", 32'(o_tx_chan), 32'(exp_q[0][9:8]));
                        if (ready && en) void'(exp_q.pop_front());
                    end
                end
                chk("halt", 32'(o_halt), 32'(m_state == 2));
                chk("exit_code", 32'(o_exit_code), 32'(m_exit));
                if (rd_q.size() > 0) chk("dout", o_dout, rd_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cyc(input logic [2:0] off, input logic [31:0] d);
        addr = {base_v[23:3], off}; din = d; wr = 1'b1;
        step();
        wr = 1'b0;
    endtask

    task automatic rd_cyc(input logic [2:0] off);
        addr = {base_v[23:3], off}; rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        step();
        rstb = 1'b1;
    endtask

    initial begin
        en = 1'b1;
        #12;
        chk("rst_dout", o_dout, 32'd0);
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_tx_data", 32'(o_tx_data), 32'd0);
        chk("rst_tx_chan", 32'(o_tx_chan), 32'd0);
        chk("rst_halt", 32'(o_halt), 32'd0);
        chk("rst_exit", 32'(o_exit_code), 32'd0);
        @(posedge clk); #1;
        rstb = 1'b1;

        // single byte on channel 0
        ready = 1'b1;
        wr_cyc(3'd6, 32'h0000_0041);
        chk("t1_valid", 32'(o_tx_valid), 32'd1);
        chk("t1_data", 32'(o_tx_data), 32'h41);
        chk("t1_chan", 32'(o_tx_chan), 32'd0);
        step();
        chk("t1_drained", 32'(o_tx_valid), 32'd0);

        // overflow: 17 writes into a 16-deep FIFO
        ready = 1'b0;
        for (int i = 0; i < 17; i++) wr_cyc(3'd6, 32'h10 + 32'(i));
        rd_cyc(3'd2);
        chk("t2_status_full", o_dout, 32'h0000_0310);
        wr_cyc(3'd2, 32'd0);
        rd_cyc(3'd2);
        chk("t2_status_clr", o_dout, 32'h0000_0210);

        // push and pop in the same cycle while full
        ready = 1'b1;
        wr_cyc(3'd6, 32'h99);
        ready = 1'b0;
        rd_cyc(3'd2);
        chk("t3_level_kept", o_dout, 32'h0000_0210);
        ready = 1'b1;
        repeat (20) step();

        // randomized traffic (HALT offset excluded from writes)
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            ready = 1'($urandom_range(0, 1));
            iv    = 1'($urandom_range(0, 1));
            din   = $urandom();
            wr = 1'b0; rd = 1'b0;
            if ($urandom_range(0, 9) < 5) begin
                wr   = 1'b1;
                addr = {base_v[23:3], 3'($urandom_range(0, 6))};
            end else begin
                rd   = ($urandom_range(0, 2) != 0);
                addr = {base_v[23:3], 3'($urandom_range(0, 7))};
            end
            if ($urandom_range(0, 7) == 0) addr = 24'($urandom()) & 24'h7F_FFFF;
            step();
        end
        wr = 1'b0; rd = 1'b0; iv = 1'b0; en = 1'b1; ready = 1'b1;
        repeat (20) step();
        chk("t4_all_drained", 32'(exp_q.size()), 32'd0);

        // counters: 100 enabled cycles, instr every other, 10 disabled cycles
        do_reset();
        for (int i = 0; i < 100; i++) begin
            iv = (i % 2 == 0);
            step();
        end
        en = 1'b0; iv = 1'b1;
        repeat (10) step();
        en = 1'b1; iv = 1'b0;
        rd_cyc(3'd1);
        chk("t5_cycle_cnt", o_dout, CNT_EN ? 32'd100 : 32'd0);
        rd_cyc(3'd0);
        chk("t5_instr_cnt", o_dout, CNT_EN ? 32'd50 : 32'd0);

        // halt with queued output
        ready = 1'b0;
        wr_cyc(3'd6, 32'h31);
        wr_cyc(3'd3, 32'h32);
        wr_cyc(3'd6, 32'h33);
        wr_cyc(3'd7, 32'h05);
        chk("t6_no_halt_yet", 32'(o_halt), 32'd0);
        wr_cyc(3'd6, 32'h77);
        rd_cyc(3'd2);
        chk("t6_status_drain", o_dout, 32'h0500_1003);
        ready = 1'b1;
        for (int i = 0; i < 30 && !o_halt; i++) step();
        chk("t6_halt", 32'(o_halt), 32'd1);
        chk("t6_exit", 32'(o_exit_code), 32'h05);
        wr_cyc(3'd7, 32'h09);
        repeat (5) step();
        rd_cyc(3'd1);
        rd_cyc(3'd2);
        chk("t6_status_halted", o_dout, 32'h0500_2400);

        // reset asserted in DRAIN
        do_reset();
        ready = 1'b0;
        wr_cyc(3'd6, 32'h51);
        wr_cyc(3'd3, 32'h52);
        wr_cyc(3'd7, 32'h22);
        rd_cyc(3'd2);
        #2;
        rstb = 1'b0;
        #1;
        chk("t7_dout", o_dout, 32'd0);
        chk("t7_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("t7_tx_data", 32'(o_tx_data), 32'd0);
        chk("t7_tx_chan", 32'(o_tx_chan), 32'd0);
        chk("t7_halt", 32'(o_halt), 32'd0);
        chk("t7_exit", 32'(o_exit_code), 32'd0);
        step();
        rstb = 1'b1;
        rd_cyc(3'd2);
        chk("t7_status_run", o_dout, 32'h0000_0400);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
